conv_tile_sequencer: RTL and testbench
======================================

Name: conv_tile_sequencer

Overview:
- Control stage directly upstream of the convolution run Counter.
- Accepts a job command (tile count) over a valid/ready handshake.
- For each tile: issues one start pulse to the Counter, waits for its done pulse, then advances the tile index and base address.
- Emits a one-cycle job-complete pulse after the last tile; supports synchronous abort with drain of the in-flight tile.

Parameters:
- TILE_MAX, 16: maximum tiles per job; larger requests are clamped to this value.
- TILE_STRIDE, 16: address increment per tile.
- ADDR_W, 8: width of tile_addr_o. Address arithmetic is modulo 2^ADDR_W.
- Derived: TILE_W = $clog2(TILE_MAX+1).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid_i  input  1  job command valid.
- cmd_ready_o  output  1  sequencer can accept a job (high only in IDLE).
- cmd_tiles_i  input  TILE_W  number of tiles in the job, 0..2^TILE_W-1.
- abort_i  input  1  synchronous abort of the current job.
- cnt_start_o  output  1  one-cycle start pulse to the Counter's start_i.
- cnt_done_i  input  1  done pulse from the Counter's done_o.
- tile_idx_o  output  TILE_W  index of the current tile.
- tile_addr_o  output  ADDR_W  base address of the current tile, equal to tile_idx*TILE_STRIDE.
- busy_o  output  1  high in every state other than IDLE.
- job_done_o  output  1  one-cycle pulse when a job completes normally.

Behaviour:
- States: IDLE, ISSUE, WAIT, DRAIN, FIN. All outputs except tile_idx_o, tile_addr_o and the optional counter are decoded combinationally from the state.
  - cnt_start_o = (ISSUE).
  - job_done_o = (FIN).
  - cmd_ready_o = (IDLE).
  - busy_o = !(IDLE).
- Reset: state = IDLE, tiles_q = 0, tile_idx_o = 0, tile_addr_o = 0. While in reset, cmd_ready_o = 1 and all other outputs are 0.
- IDLE:
  - On cmd_valid_i & cmd_ready_o: latch tiles_q = min(cmd_tiles_i, TILE_MAX), and clear tile_idx_o and tile_addr_o to 0.
  - Next state is FIN if the latched value is 0, otherwise ISSUE.
  - abort_i is ignored in IDLE.
- ISSUE: lasts exactly one cycle, then WAIT. If abort_i is high, go to DRAIN instead; the start pulse is still issued in this cycle.
- WAIT:
  - If abort_i is high:
    - with cnt_done_i high in the same cycle, go to IDLE;
    - otherwise go to DRAIN.
  - Else, on cnt_done_i:
    - if tile_idx_o == tiles_q-1, go to FIN;
    - otherwise increment tile_idx_o, add TILE_STRIDE to tile_addr_o, and go to ISSUE.
- DRAIN: wait for cnt_done_i, then go to IDLE. No further start pulse and no job_done_o pulse.
- FIN: lasts one cycle, then IDLE. abort_i is ignored.
- cnt_done_i is ignored in IDLE, ISSUE and FIN.
- tile_idx_o and tile_addr_o hold their values in IDLE after a job; they change only on command accept or tile advance.
- Timing with a Counter of COUNT_NUM = C:
  - Counter returns to its IDLE state one cycle after done, so each ISSUE is seen by an idle Counter.
  - Per-tile period is C+2 cycles.
  - With the command accepted at the edge ending cycle 0, tile k starts in cycle 1+k(C+2), and job_done_o is high in cycle N(C+2)+1.
  - A 0-tile job gives job_done_o in cycle 1.
- Reset asserted mid-job: immediate return to the reset state. The Counter is reset by the same rst_n.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined:
  - Adds output job_cycles_o, 16 bits, reset value 0.
  - Cleared to 1 on command accept, then incremented by 1 each cycle while busy_o is high, saturating at 16'hFFFF.
  - Holds its value in IDLE until the next accept.
  - After a normal job it equals the number of busy cycles, FIN included. After an abort it counts through DRAIN.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Bench setup: TILE_MAX=16, TILE_STRIDE=16, ADDR_W=8, real Counter with COUNT_NUM=4 (C=4).
- Reset, then hold idle: cmd_ready_o=1; busy_o, cnt_start_o and job_done_o = 0; tile_addr_o = 0.
- Accept cmd_tiles_i=3 at cycle 0 -> cnt_start_o high in cycles 1, 7, 13; tile_addr_o = 0, 16, 32; job_done_o high only in cycle 19; job_cycles_o = 19 when macro defined.
- Accept cmd_tiles_i=0 -> job_done_o in cycle 1, cnt_start_o never high.
- Accept cmd_tiles_i=20 -> clamped to 16 start pulses; last tile_idx_o = 15, tile_addr_o = 240; job_done_o at cycle 97.
- cmd_tiles_i=3, abort_i pulsed in cycle 3 (WAIT) -> DRAIN until Counter done (cycle 6), IDLE in cycle 7; no job_done_o; no further cnt_start_o.
- abort_i coincident with cnt_done_i in WAIT -> IDLE next cycle. Separately, rst_n asserted mid-WAIT -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/conv_tile_sequencer.sv
// Tile sequencer feeding the convolution run Counter: accepts a job, issues one
// start per tile, tracks tile index/address. `SEQ_PERF_CNT_EN adds job_cycles_o.
module conv_tile_sequencer #(
    parameter int  TILE_MAX    = 16,
    parameter int  TILE_STRIDE = 16,
    parameter int  ADDR_W      = 8,
    localparam int TILE_W      = $clog2(TILE_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [TILE_W-1:0] cmd_tiles_i,
    input  logic              abort_i,
    output logic              cnt_start_o,
    input  logic              cnt_done_i,
    output logic [TILE_W-1:0] tile_idx_o,
    output logic [ADDR_W-1:0] tile_addr_o,
    output logic              busy_o,
    output logic              job_done_o
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]       job_cycles_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_FIN
    } state_t;

    localparam logic [TILE_W-1:0] TILE_MAX_C = TILE_W'(TILE_MAX);
    localparam logic [ADDR_W-1:0] STRIDE_C   = ADDR_W'(TILE_STRIDE);

    state_t            state_q, state_d;
    logic [TILE_W-1:0] tiles_q, tiles_d;
    logic [TILE_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TILE_W-1:0] clamped_tiles;
    logic              accept;

    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign cnt_start_o = (state_q == S_ISSUE);
    assign job_done_o  = (state_q == S_FIN);
    assign tile_idx_o  = idx_q;
    assign tile_addr_o = addr_q;

    assign accept        = cmd_valid_i && cmd_ready_o;
    assign clamped_tiles = (cmd_tiles_i > TILE_MAX_C) ? TILE_MAX_C : cmd_tiles_i;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d = state_q;
        tiles_d = tiles_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tiles_d = clamped_tiles;
                    idx_d   = '0;
                    addr_d  = '0;
                    state_d = (clamped_tiles == '0) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = abort_i ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (abort_i) begin
                    // A done arriving with the abort means the tile already drained.
                    state_d = cnt_done_i ? S_IDLE : S_DRAIN;
                end else if (cnt_done_i) begin
                    if (idx_q == tiles_q - TILE_W'(1)) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q + TILE_W'(1);
                        addr_d  = addr_q + STRIDE_C;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_done_i) begin
                    state_d = S_IDLE;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tiles_q <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            tiles_q <= tiles_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] cycles_q;

    // Value in busy cycle n is n; the final busy cycle does not bump it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_q <= '0;
        end else if (accept) begin
            cycles_q <= 16'd1;
        end else if (busy_o && (state_d != S_IDLE) && !(&cycles_q)) begin
            cycles_q <= cycles_q + 16'd1;
        end
    end

    assign job_cycles_o = cycles_q;
`endif

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Scoreboard bench for conv_tile_sequencer with a behavioural Counter (C=4).
module tb_conv_tile_sequencer;

    localparam int C      = 4;
    localparam int P      = C + 2;
    localparam int TILE_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid_i = 1'b0;
    logic              cmd_ready_o;
    logic [TILE_W-1:0] cmd_tiles_i = '0;
    logic              abort_i = 1'b0;
    logic              cnt_start_o;
    logic              cnt_done_i;
    logic [TILE_W-1:0] tile_idx_o;
    logic [7:0]        tile_addr_o;
    logic              busy_o;
    logic              job_done_o;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0]       job_cycles_o;
`endif

    conv_tile_sequencer #(.TILE_MAX(16), .TILE_STRIDE(16), .ADDR_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_tiles_i (cmd_tiles_i),
        .abort_i     (abort_i),
        .cnt_start_o (cnt_start_o),
        .cnt_done_i  (cnt_done_i),
        .tile_idx_o  (tile_idx_o),
        .tile_addr_o (tile_addr_o),
        .busy_o      (busy_o),
        .job_done_o  (job_done_o)
`ifdef SEQ_PERF_CNT_EN
        ,
        .job_cycles_o(job_cycles_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int t0  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Counter model: start in cycle s gives done in cycle s+C+1.
    logic [3:0] ccnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            ccnt <= '0;
        else if (cnt_start_o)  ccnt <= 4'(C + 1);
        else if (ccnt != 4'd0) ccnt <= ccnt - 4'd1;
    end
    assign cnt_done_i = (ccnt == 4'd1);

    typedef struct {
        int cycle;
        int idx;
        int addr;
    } ev_t;

    ev_t start_q[$];
    int  done_q[$];
    ev_t mon_e;
    int  mon_d;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cnt_start_o) begin
                check("start_expected", int'(start_q.size() != 0), 1);
                if (start_q.size() != 0) begin
                    mon_e = start_q.pop_front();
                    check("start_cycle", cyc - t0, mon_e.cycle);
                    check("start_idx", int'(tile_idx_o), mon_e.idx);
                    check("start_addr", int'(tile_addr_o), mon_e.addr);
                end
            end
            if (job_done_o) begin
                check("done_expected", int'(done_q.size() != 0), 1);
                if (done_q.size() != 0) begin
                    mon_d = done_q.pop_front();
                    check("done_cycle", cyc - t0, mon_d);
                end
            end
        end
    end

    task automatic accept_cmd(input int tiles);
        @(posedge clk); #1;
        cmd_valid_i = 1'b1;
        cmd_tiles_i = TILE_W'(tiles);
        t0 = cyc;
    endtask

    task automatic run_job(input int tiles, input int n);
        for (int k = 0; k < n; k++) start_q.push_back('{1 + k * P, k, (k * 16) % 256});
        done_q.push_back(n * P + 1);
        accept_cmd(tiles);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 300 && busy_o; i++) begin
            @(posedge clk); #1;
        end
        check("idle_after_job", int'(busy_o), 0);
        check("start_q_empty", start_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        check("idx_hold", int'(tile_idx_o), (n == 0) ? 0 : n - 1);
        check("addr_hold", int'(tile_addr_o), (n == 0) ? 0 : ((n - 1) * 16) % 256);
`ifdef SEQ_PERF_CNT_EN
        check("job_cycles", int'(job_cycles_o), n * P + 1);
`endif
    endtask

    // 3-tile job aborted in cycle abort_at; tile 0 drains and the sequencer idles in cycle 7.
    task automatic run_abort(input int abort_at);
        start_q.push_back('{1, 0, 0});
        accept_cmd(3);
        for (int r = 1; r <= 7; r++) begin
            @(posedge clk); #1;
            cmd_valid_i = 1'b0;
            abort_i     = (r == abort_at);
            if (r == 6) check("busy_before_idle", int'(busy_o), 1);
        end
        check("abort_idle", int'(busy_o), 0);
        check("abort_ready", int'(cmd_ready_o), 1);
        repeat (3) @(posedge clk);
        #1;
        check("abort_stays_idle", int'(busy_o), 0);
        check("abort_start_q_empty", start_q.size(), 0);
        check("abort_done_q_empty", done_q.size(), 0);
`ifdef SEQ_PERF_CNT_EN
        check("abort_job_cycles", int'(job_cycles_o), 6);
`endif
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ready"}, int'(cmd_ready_o), 1);
        check({pfx, "_busy"}, int'(busy_o), 0);
        check({pfx, "_start"}, int'(cnt_start_o), 0);
        check({pfx, "_done"}, int'(job_done_o), 0);
        check({pfx, "_idx"}, int'(tile_idx_o), 0);
        check({pfx, "_addr"}, int'(tile_addr_o), 0);
`ifdef SEQ_PERF_CNT_EN
        check({pfx, "_cycles"}, int'(job_cycles_o), 0);
`endif
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("idle_hold");

        run_job(3, 3);
        run_job(0, 0);
        run_job(20, 16);
        run_job(1, 1);
        run_abort(3);
        run_abort(6);
        run_abort(1);

        // Reset in the WAIT of tile 1, where index and address are non-zero.
        start_q.push_back('{1, 0, 0});
        start_q.push_back('{7, 1, 16});
        accept_cmd(3);
        for (int r = 1; r <= 9; r++) begin
            @(posedge clk); #1;
            cmd_valid_i = 1'b0;
        end
        check("pre_reset_addr", int'(tile_addr_o), 16);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_reset_busy", int'(busy_o), 0);
        check("reset_start_q_empty", start_q.size(), 0);

        run_job(2, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
